// File: rtl/mul32_seq.sv
// Sequential shift-add multiplier for MULT/MULTU: one multiplier bit per clock,
// full 2*WIDTH-bit product written to hi/lo with a one-cycle done pulse.
module mul32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cancel,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t               r_state, w_state_nx;
   logic [2*WIDTH-1:0]   r_acc, w_acc_nx;
   logic [WIDTH-1:0]     r_mcand, w_mcand_nx;
   logic [WIDTH-1:0]     r_hi, w_hi_nx;
   logic [WIDTH-1:0]     r_lo, w_lo_nx;
   logic [CW-1:0]        r_cnt, w_cnt_nx;
   logic                 r_neg, w_neg_nx;
   logic                 r_done, w_done_nx;

   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH-1:0]     w_addend;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_acc_sh;
   logic [2*WIDTH-1:0]   w_prod;
   logic                 w_last;

   // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
   assign w_abs_a = (signed_op & a[WIDTH-1]) ? -a : a;
   assign w_abs_b = (signed_op & b[WIDTH-1]) ? -b : b;

   // Multiplier lives in the low half of the accumulator and shifts out as
   // product bits shift in, so r_acc[0] is always the current multiplier bit.
   assign w_addend = r_acc[0] ? r_mcand : '0;
   assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
   assign w_acc_sh = {w_sum, r_acc[WIDTH-1:1]};
   assign w_prod   = r_neg ? -w_acc_sh : w_acc_sh;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_state_nx = r_state;
      w_acc_nx   = r_acc;
      w_mcand_nx = r_mcand;
      w_hi_nx    = r_hi;
      w_lo_nx    = r_lo;
      w_cnt_nx   = r_cnt;
      w_neg_nx   = r_neg;
      w_done_nx  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start && !cancel) begin
               w_state_nx = RUN;
               w_mcand_nx = w_abs_a;
               w_acc_nx   = {{WIDTH{1'b0}}, w_abs_b};
               w_neg_nx   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
               w_cnt_nx   = '0;
            end
         end
         RUN: begin
            if (cancel) begin
               w_state_nx = IDLE;
            end else begin
               w_acc_nx = w_acc_sh;
               w_cnt_nx = r_cnt + CW'(1);
               if (w_last) begin
                  w_hi_nx    = w_prod[2*WIDTH-1:WIDTH];
                  w_lo_nx    = w_prod[WIDTH-1:0];
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_acc   <= w_acc_nx;
         r_mcand <= w_mcand_nx;
         r_hi    <= w_hi_nx;
         r_lo    <= w_lo_nx;
         r_cnt   <= w_cnt_nx;
         r_neg   <= w_neg_nx;
         r_done  <= w_done_nx;
      end
   end

   assign busy = (r_state == RUN);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboard bench for mul32_seq: stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_mul32_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cancel = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   mul32_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cancel    (cancel),
      .signed_op (signed_op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] prod;
      int          due;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] model(logic [31:0] x, logic [31:0] y,
                                         logic s);
      longint sx;
      longint sy;
      if (s) begin
         sx = $signed(x);
         sy = $signed(y);
         return 64'(sx * sy);
      end
      return {32'b0, x} * {32'b0, y};
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected none");
         end else begin
            m_e = q.pop_front();
            chk("product", {hi, lo}, m_e.prod);
            chk("latency", 64'(cyc), 64'(m_e.due));
         end
      end
   end

   // Start edge is the next posedge; operands are scrambled right after it.
   task automatic issue(logic [31:0] x, logic [31:0] y, logic s,
                        bit push, logic [63:0] exp);
      exp_t e;
      a = x;
      b = y;
      signed_op = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.prod = exp;
         e.due  = cyc + 32;
         q.push_back(e);
      end
      a = $urandom;
      b = $urandom;
      signed_op = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(n < 300), 64'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 64'(done), 64'd1);
   endtask

   initial begin
      int nb;
      logic [31:0] x;
      logic [31:0] y;
      logic        s;

      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE_00000001);
      nb = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy) nb++;
      end
      chk("busy_cycles", 64'(nb), 64'd32);
      drain();

      issue(32'hFFFFFFFD, 32'd7, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
      drain();
      issue(32'hFFFFFFFD, 32'd7, 1'b0, 1'b1, 64'h00000006_FFFFFFEB);
      drain();
      issue(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000);
      drain();
      issue(32'h80000000, 32'd1, 1'b1, 1'b1, 64'hFFFFFFFF_80000000);
      drain();
      issue(32'd0, 32'hDEADBEEF, 1'b1, 1'b1, 64'd0);
      drain();

      issue(32'd5, 32'd6, 1'b0, 1'b1, 64'd30);
      drain();
      issue(32'h1234, 32'h10, 1'b0, 1'b0, 64'd0);
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      chk("cancel_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      chk("cancel_hold", {hi, lo}, 64'd30);
      issue(32'd2, 32'd3, 1'b0, 1'b1, 64'd6);
      drain();

      cancel = 1'b1;
      issue(32'd9, 32'd9, 1'b0, 1'b0, 64'd0);
      cancel = 1'b0;
      chk("cancel_start_idle", 64'(busy), 64'd0);
      issue(32'd11, 32'd13, 1'b0, 1'b0, 64'd0);
      repeat (31) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      chk("cancel_last_busy", 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      chk("cancel_last_hold", {hi, lo}, 64'd6);

      issue(32'd100, 32'd200, 1'b0, 1'b1, 64'd20000);
      repeat (4) @(posedge clk);
      #1;
      a = 32'd77;
      b = 32'd88;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      issue(32'd7, 32'd9, 1'b0, 1'b1, 64'd63);
      drain();

      issue(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 64'd0);
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_done", 64'(done), 64'd0);
      chk("async_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      issue(32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFE);
      drain();

      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         y = $urandom;
         s = 1'($urandom_range(0, 1));
         if (i % 8 == 1) x = 32'h80000000;
         if (i % 8 == 5) y = 32'hFFFFFFFF;
         issue(x, y, s, 1'b1, model(x, y, s));
         wait_done();
         if ($urandom_range(0, 1) == 1) repeat (2) @(negedge clk);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
